// File: rtl/assert_log.sv
// assert_log: synthesizable companion to an assertion site.
// Counts pass/fail events and queues {id, timestamp} records of failures
// in a small FIFO that a host drains through a one-cycle read handshake.
module assert_log #(
    parameter int DEPTH     = 8,
    parameter int ID_WIDTH  = 8,
    parameter int TS_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic                       a,
    input  logic [ID_WIDTH-1:0]        id,
    input  logic                       clr,
    input  logic                       rd_req,
    output logic                       rd_ack,
    output logic                       rd_valid,
    output logic [ID_WIDTH-1:0]        rd_id,
    output logic [TS_WIDTH-1:0]        rd_time,
    output logic [CNT_WIDTH-1:0]       pass_cnt,
    output logic [CNT_WIDTH-1:0]       fail_cnt,
    output logic [CNT_WIDTH-1:0]       drop_cnt,
    output logic                       fail_sticky,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int RW = ID_WIDTH + TS_WIDTH;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [TS_WIDTH-1:0]  TS_ONE   = TS_WIDTH'(1);
    localparam logic [PW-1:0]        PTR_ONE  = PW'(1);
    localparam logic [LW-1:0]        LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]        LVL_FULL = LW'(DEPTH);

    logic [TS_WIDTH-1:0] ts;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [RW-1:0]       mem [DEPTH];

    logic pass_ev;
    logic fail_ev;
    logic pop;
    logic push;
    logic drop;
    logic full;

    // Event qualification; clr masks both events and pops in its cycle.
    // A full FIFO still accepts a push when a pop frees a slot the same cycle.
    always_comb begin
        full    = (level == LVL_FULL);
        pass_ev = req & a & ~clr;
        fail_ev = req & ~a & ~clr;
        pop     = rd_req & ~clr & (level != '0);
        push    = fail_ev & (~full | pop);
        drop    = fail_ev & ~push;
    end

    // Free-running timestamp, untouched by clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts <= '0;
        else      ts <= ts + TS_ONE;
    end

    // Record storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {id, ts};
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Saturating counters and the sticky failure flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            drop_cnt    <= '0;
            fail_sticky <= 1'b0;
        end else if (clr) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            drop_cnt    <= '0;
            fail_sticky <= 1'b0;
        end else begin
            if (pass_ev && pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
            if (fail_ev && fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
            if (drop && drop_cnt != CNT_MAX)    drop_cnt <= drop_cnt + CNT_ONE;
            if (fail_ev)                        fail_sticky <= 1'b1;
        end
    end

    // Read response: every rd_req is acked next cycle; data only moves on a pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ack   <= 1'b0;
            rd_valid <= 1'b0;
            rd_id    <= '0;
            rd_time  <= '0;
        end else begin
            rd_ack   <= rd_req;
            rd_valid <= pop;
            if (pop) {rd_id, rd_time} <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_assert_log.sv
// Directed bench for assert_log: a default instance plus a 4-bit-counter
// instance sharing the same stimulus, used for the saturation check.
module tb_assert_log;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, a, clr, rd_req;
    logic [7:0]  id;

    logic        rd_ack, rd_valid, fail_sticky;
    logic [7:0]  rd_id;
    logic [31:0] rd_time;
    logic [15:0] pass_cnt, fail_cnt, drop_cnt;
    logic [3:0]  level;

    logic        rd_ack4, rd_valid4, fail_sticky4;
    logic [7:0]  rd_id4;
    logic [31:0] rd_time4;
    logic [3:0]  pass_cnt4, fail_cnt4, drop_cnt4;
    logic [3:0]  level4;

    int ncmp = 0;
    int nerr = 0;
    int cur_ts;
    int t0;

    always #5 clk = ~clk;

    assert_log dut (
        .clk(clk), .rst(rst), .req(req), .a(a), .id(id), .clr(clr),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid),
        .rd_id(rd_id), .rd_time(rd_time), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .drop_cnt(drop_cnt),
        .fail_sticky(fail_sticky), .level(level)
    );

    assert_log #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .a(a), .id(id), .clr(clr),
        .rd_req(rd_req), .rd_ack(rd_ack4), .rd_valid(rd_valid4),
        .rd_id(rd_id4), .rd_time(rd_time4), .pass_cnt(pass_cnt4),
        .fail_cnt(fail_cnt4), .drop_cnt(drop_cnt4),
        .fail_sticky(fail_sticky4), .level(level4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cur_ts++;
    endtask

    task automatic idle();
        req = 1'b0; a = 1'b0; clr = 1'b0; rd_req = 1'b0; id = 8'h00;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #12;
        chk("rst_pass", pass_cnt, 0);
        chk("rst_ack", rd_ack, 0);
        chk("rst_level", level, 0);
        rst = 1'b1;
        cur_ts = 0;

        // three passes
        req = 1'b1; a = 1'b1;
        repeat (3) step();
        idle();
        chk("t1_pass", pass_cnt, 3);
        chk("t1_fail", fail_cnt, 0);
        chk("t1_sticky", fail_sticky, 0);
        chk("t1_level", level, 0);

        // single fail at ts=10, read at ts=12
        while (cur_ts < 10) step();
        req = 1'b1; a = 1'b0; id = 8'h12;
        step();
        idle();
        chk("t2_sticky", fail_sticky, 1);
        chk("t2_fail", fail_cnt, 1);
        chk("t2_level", level, 1);
        step();
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk("t2_ts", cur_ts, 13);
        chk("t2_ack", rd_ack, 1);
        chk("t2_valid", rd_valid, 1);
        chk("t2_id", rd_id, 8'h12);
        chk("t2_time", rd_time, 10);
        chk("t2_level0", level, 0);
        step();
        chk("t2_ack_low", rd_ack, 0);
        chk("t2_id_hold", rd_id, 8'h12);

        // ten fails into an 8-deep FIFO, then nine back-to-back reads
        clr = 1'b1;
        step();
        idle();
        chk("t3_clr_fail", fail_cnt, 0);
        t0 = cur_ts;
        for (int i = 0; i < 10; i++) begin
            req = 1'b1; a = 1'b0; id = 8'(8'h20 + i);
            step();
        end
        idle();
        chk("t3_fail", fail_cnt, 10);
        chk("t3_drop", drop_cnt, 2);
        chk("t3_level", level, 8);
        rd_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("t3_ack", rd_ack, 1);
            if (i < 8) begin
                chk("t3_valid", rd_valid, 1);
                chk("t3_id", rd_id, 8'(8'h20 + i));
                chk("t3_time", rd_time, 32'(t0 + i));
            end else begin
                chk("t3_valid_empty", rd_valid, 0);
            end
        end
        rd_req = 1'b0;
        chk("t3_level0", level, 0);

        // full FIFO: fail plus read in the same cycle
        for (int i = 0; i < 8; i++) begin
            req = 1'b1; a = 1'b0; id = 8'(8'h40 + i);
            step();
        end
        chk("t4_full", level, 8);
        req = 1'b1; a = 1'b0; id = 8'h55; rd_req = 1'b1;
        step();
        idle();
        chk("t4_level", level, 8);
        chk("t4_drop", drop_cnt, 2);
        chk("t4_fail", fail_cnt, 19);
        chk("t4_valid", rd_valid, 1);
        chk("t4_id", rd_id, 8'h40);
        rd_req = 1'b1;
        for (int i = 1; i < 9; i++) begin
            step();
            chk("t4_drain_id", rd_id, (i < 8) ? 8'(8'h40 + i) : 8'h55);
        end
        rd_req = 1'b0;
        chk("t4_level0", level, 0);

        // push and pop on an empty FIFO
        req = 1'b1; a = 1'b0; id = 8'h77; rd_req = 1'b1;
        step();
        idle();
        chk("t5_empty_valid", rd_valid, 0);
        chk("t5_empty_level", level, 1);

        // clr with a coincident fail and read
        req = 1'b1; a = 1'b0; id = 8'h88; rd_req = 1'b1; clr = 1'b1;
        step();
        idle();
        chk("t6_pass", pass_cnt, 0);
        chk("t6_fail", fail_cnt, 0);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_sticky", fail_sticky, 0);
        chk("t6_level", level, 0);
        chk("t6_ack", rd_ack, 1);
        chk("t6_valid", rd_valid, 0);

        // saturation on the 4-bit instance
        req = 1'b1; a = 1'b1;
        repeat (20) step();
        chk("t7_sat4", pass_cnt4, 15);
        chk("t7_pass16", pass_cnt, 20);

        // asynchronous reset mid-stream with a read ack in flight
        a = 1'b0; rd_req = 1'b1;
        step();
        chk("t8_pre_ack", rd_ack, 1);
        chk("t8_pre_sticky", fail_sticky, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t8_ack", rd_ack, 0);
        chk("t8_valid", rd_valid, 0);
        chk("t8_id", rd_id, 0);
        chk("t8_time", rd_time, 0);
        chk("t8_pass", pass_cnt, 0);
        chk("t8_fail", fail_cnt, 0);
        chk("t8_drop", drop_cnt, 0);
        chk("t8_sticky", fail_sticky, 0);
        chk("t8_level", level, 0);
        chk("t8_pass4", pass_cnt4, 0);
        idle();
        #1;
        rst = 1'b1;
        step();
        chk("t8_no_ack", rd_ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
